// File: rtl/prf_wb_arbiter.sv
// Round-robin writeback arbiter: grants up to NUM_WPORTS of NUM_REQ result
// producers per cycle and registers the winners onto the register-file write ports.
module prf_wb_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int NUM_WPORTS = 2,
    parameter int PRN_BITS   = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [PRN_BITS-1:0]   req_prn [NUM_REQ],
    input  logic [63:0]           req_data [NUM_REQ],
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_WPORTS-1:0] wb_wen,
    output logic [PRN_BITS-1:0]   wb_wprn [NUM_WPORTS],
    output logic [63:0]           wb_wdata [NUM_WPORTS],
    output logic [31:0]           grant_count
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]      rr_ptr;
    logic [PTR_W-1:0]      rr_next;
    logic [PTR_W-1:0]      port_src [NUM_WPORTS];
    logic [NUM_WPORTS-1:0] port_vld;
    logic [31:0]           grant_num;
    logic                  dup_prn;

    // Scan from rr_ptr upward; the k-th valid requester found lands on port k.
    // Grants are suppressed during reset and flush, so only valid, rr_ptr,
    // flush and rst_n reach req_ready -- never the payload.
    always_comb begin
        int cnt;
        int idx;
        // NOTE: every comb output gets a default before any branch so no latch is inferred.
        req_ready = '0;
        port_vld  = '0;
        rr_next   = rr_ptr;
        cnt       = 0;
        idx       = 0;
        for (int k = 0; k < NUM_WPORTS; k++) begin
            port_src[k] = '0;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                if (j == idx && req_valid[j] && rst_n && !flush && cnt < NUM_WPORTS) begin
                    req_ready[j] = 1'b1;
                    for (int k = 0; k < NUM_WPORTS; k++) begin
                        if (k == cnt) begin
                            port_vld[k] = 1'b1;
                            port_src[k] = PTR_W'(j);
                        end
                    end
                    rr_next = (j == NUM_REQ - 1) ? '0 : PTR_W'(j + 1);
                    cnt     = cnt + 1;
                end
            end
        end
        grant_num = 32'(cnt);
    end

    // Two ports writing the same PRN in one cycle means the rename stage broke.
    always_comb begin
        dup_prn = 1'b0;
        for (int a = 0; a < NUM_WPORTS; a++) begin
            for (int b = a + 1; b < NUM_WPORTS; b++) begin
                if (port_vld[a] && port_vld[b] &&
                    req_prn[port_src[a]] == req_prn[port_src[b]]) begin
                    dup_prn = 1'b1;
                end
            end
        end
    end

    a_unique_prn: assert property (@(posedge clk) disable iff (!rst_n) !dup_prn);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr      <= '0;
            grant_count <= '0;
            wb_wen      <= '0;
            for (int k = 0; k < NUM_WPORTS; k++) begin
                wb_wprn[k]  <= '0;
                wb_wdata[k] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all registers sample the same pre-edge values.
            wb_wen <= port_vld;
            for (int k = 0; k < NUM_WPORTS; k++) begin
                wb_wprn[k]  <= port_vld[k] ? req_prn[port_src[k]]  : '0;
                wb_wdata[k] <= port_vld[k] ? req_data[port_src[k]] : '0;
            end
            grant_count <= grant_count + grant_num;
            if (|port_vld) begin
                rr_ptr <= rr_next;
            end
        end
    end

endmodule

// File: tb/tb_prf_wb_arbiter.sv
// Directed bench for prf_wb_arbiter: the driver checks req_ready and queues the
// expected writeback; a monitor pops and compares one cycle later.
module tb_prf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [5:0]  req_prn [4];
    logic [63:0] req_data [4];
    logic [3:0]  req_ready;
    logic [1:0]  wb_wen;
    logic [5:0]  wb_wprn [2];
    logic [63:0] wb_wdata [2];
    logic [31:0] grant_count;

    prf_wb_arbiter #(.NUM_REQ(4), .NUM_WPORTS(2), .PRN_BITS(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_prn     (req_prn),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .wb_wen      (wb_wen),
        .wb_wprn     (wb_wprn),
        .wb_wdata    (wb_wdata),
        .grant_count (grant_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  wen;
        logic [5:0]  prn0;
        logic [5:0]  prn1;
        logic [63:0] d0;
        logic [63:0] d1;
        logic [31:0] gc;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          passes = 0;
    logic [31:0] exp_gc = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Expected writeback for grants p0/p1 (requester index, -1 = idle port).
    task automatic push_exp(input int p0, input int p1);
        exp_t e;
        e.wen  = {p1 >= 0, p0 >= 0};
        e.prn0 = (p0 >= 0) ? req_prn[p0]  : 6'd0;
        e.prn1 = (p1 >= 0) ? req_prn[p1]  : 6'd0;
        e.d0   = (p0 >= 0) ? req_data[p0] : 64'd0;
        e.d1   = (p1 >= 0) ? req_data[p1] : 64'd0;
        exp_gc = exp_gc + 32'(p0 >= 0) + 32'(p1 >= 0);
        e.gc   = exp_gc;
        sb_q.push_back(e);
    endtask

    task automatic drive(input logic [3:0] v, input logic f, input logic [3:0] exp_rdy,
                         input int p0, input int p1);
        @(negedge clk);
        req_valid = v;
        flush     = f;
        #1;
        check($sformatf("ready v=%b f=%b", v, f), 64'(req_ready), 64'(exp_rdy));
        push_exp(p0, p1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("wb_wen",      64'(wb_wen),      64'(e.wen));
                check("wb_wprn0",    64'(wb_wprn[0]),  64'(e.prn0));
                check("wb_wprn1",    64'(wb_wprn[1]),  64'(e.prn1));
                check("wb_wdata0",   wb_wdata[0],      e.d0);
                check("wb_wdata1",   wb_wdata[1],      e.d1);
                check("grant_count", 64'(grant_count), 64'(e.gc));
            end
        end
    end

    initial begin : stimulus
        int guard;
        req_prn[0]  = 6'd10; req_data[0] = 64'h1111_0000_0000_0001;
        req_prn[1]  = 6'd11; req_data[1] = 64'h2222_0000_0000_0002;
        req_prn[2]  = 6'd5;  req_data[2] = 64'h0000_0000_0000_DEAD;
        req_prn[3]  = 6'd13; req_data[3] = 64'h4444_0000_0000_0004;

        // Reset held with all requesters valid: nothing may be granted.
        req_valid = 4'b1111;
        #1;
        check("ready in reset", 64'(req_ready), 64'd0);
        repeat (2) @(negedge clk);
        check("reset wb_wen", 64'(wb_wen), 64'd0);
        check("reset wb_wdata0", wb_wdata[0], 64'd0);
        check("reset grant_count", 64'(grant_count), 64'd0);
        req_valid = 4'b0000;
        rst_n     = 1'b1;

        drive(4'b1111, 1'b0, 4'b0011, 0, 1);    // rr 0 -> 2
        drive(4'b1111, 1'b0, 4'b1100, 2, 3);    // rr 2 -> 0
        drive(4'b0100, 1'b0, 4'b0100, 2, -1);   // prn 5 / 0xDEAD on port 0, rr -> 3
        drive(4'b1111, 1'b1, 4'b0000, -1, -1);  // flush: rr stays 3
        drive(4'b1001, 1'b0, 4'b1001, 3, 0);    // wrap: port0=req3, port1=req0, rr -> 1, count 7

        // Asynchronous reset pulse in the middle of a granting cycle.
        @(negedge clk);
        req_valid = 4'b1111;
        #1;
        check("count before reset", 64'(grant_count), 64'd7);
        check("ready before reset", 64'(req_ready), 64'b0110);
        #1;
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        exp_gc = '0;
        check("ready at reset", 64'(req_ready), 64'd0);
        check("wen at reset", 64'(wb_wen), 64'd0);
        check("count at reset", 64'(grant_count), 64'd0);
        @(posedge clk);
        #1;
        check("wen during reset", 64'(wb_wen), 64'd0);
        @(negedge clk);
        req_valid = 4'b0000;
        rst_n     = 1'b1;

        drive(4'b1010, 1'b0, 4'b1010, 1, 3);    // rr restarts at 0 -> lowest valid first
        drive(4'b1111, 1'b0, 4'b0011, 0, 1);    // rr -> 2
        drive(4'b0000, 1'b0, 4'b0000, -1, -1);
        drive(4'b0011, 1'b0, 4'b0011, 0, 1);    // scan 2,3,0,1; rr -> 2
        drive(4'b0001, 1'b0, 4'b0001, 0, -1);   // rr -> 1
        drive(4'b1110, 1'b0, 4'b0110, 1, 2);    // rr -> 3
        drive(4'b0110, 1'b0, 4'b0110, 1, 2);    // rr stays 3

        // Preload the counter just below the 32-bit wrap during an idle cycle.
        @(negedge clk);
        req_valid = 4'b0000;
        dut.grant_count = 32'hFFFF_FFFD;
        exp_gc = 32'hFFFF_FFFD;
        push_exp(-1, -1);

        drive(4'b1111, 1'b0, 4'b1001, 3, 0);    // count 0xFFFFFFFF, rr -> 1
        drive(4'b1111, 1'b0, 4'b0110, 1, 2);    // count wraps to 0x00000001
        drive(4'b0000, 1'b0, 4'b0000, -1, -1);

        guard = 0;
        while (sb_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        repeat (2) @(posedge clk);
        check("scoreboard drained", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
